// File: rtl/interrupt_ctrl.sv
// Interrupt controller: synchronizes NMI/IRQ pins, arbitrates reset > NMI > BRK > IRQ
// at instruction boundaries and sequences the take / acknowledge handshake.
module interrupt_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        fetch_req,
    input  logic        brk,
    input  logic        ack,
    output logic        int_take,
    output logic [15:0] vector,
    output logic        push_b,
    output logic        set_i,
    output logic        busy
);

    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    typedef enum logic [1:0] {RST_PEND, IDLE, SERVICE} state_t;
    typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_BRK, SRC_IRQ} src_t;

    state_t state_q;
    src_t   src_q;

    logic nmi_s1_q;
    logic nmi_s2_q;
    logic nmi_prev_q;
    logic irq_s1_q;
    logic irq_s2_q;
    logic nmi_latch_q;

    logic nmi_fall_c;
    logic irq_pend_c;
    logic nmi_clr_c;
    logic any_src_c;

    // Two-flop synchronizers; idle-high so reset never looks like a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_s1_q   <= 1'b1;
            nmi_s2_q   <= 1'b1;
            nmi_prev_q <= 1'b1;
            irq_s1_q   <= 1'b1;
            irq_s2_q   <= 1'b1;
        end else begin
            nmi_s1_q   <= nmi_n;
            nmi_s2_q   <= nmi_s1_q;
            nmi_prev_q <= nmi_s2_q;
            irq_s1_q   <= irq_n;
            irq_s2_q   <= irq_s1_q;
        end
    end

    assign nmi_fall_c = nmi_prev_q & ~nmi_s2_q;
    assign irq_pend_c = ~irq_s2_q & ~i_flag;
    assign nmi_clr_c  = (state_q == SERVICE) && ack && (src_q == SRC_NMI);
    assign any_src_c  = nmi_latch_q | brk | irq_pend_c;

    // A new edge wins over the clear so a back-to-back NMI is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_latch_q <= 1'b0;
        end else if (nmi_fall_c) begin
            nmi_latch_q <= 1'b1;
        end else if (nmi_clr_c) begin
            nmi_latch_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RST_PEND;
            src_q    <= SRC_RST;
            int_take <= 1'b0;
            set_i    <= 1'b0;
            busy     <= 1'b0;
            push_b   <= 1'b0;
            vector   <= VEC_RST;
        end else begin
            int_take <= 1'b0;
            set_i    <= 1'b0;
            case (state_q)
                RST_PEND: begin
                    if (fetch_req) begin
                        int_take <= 1'b1;
                        busy     <= 1'b1;
                        vector   <= VEC_RST;
                        push_b   <= 1'b0;
                        src_q    <= SRC_RST;
                        state_q  <= SERVICE;
                    end
                end
                IDLE: begin
                    if (fetch_req && any_src_c) begin
                        int_take <= 1'b1;
                        busy     <= 1'b1;
                        push_b   <= brk;
                        state_q  <= SERVICE;
                        if (nmi_latch_q) begin
                            vector <= VEC_NMI;
                            src_q  <= SRC_NMI;
                        end else begin
                            vector <= VEC_IRQ;
                            src_q  <= brk ? SRC_BRK : SRC_IRQ;
                        end
                    end
                end
                SERVICE: begin
                    if (ack) begin
                        set_i   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= RST_PEND;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed scenarios plus random traffic, all checked
// against a transaction-level reference model.
module tb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nmi_n = 1'b1;
    logic        irq_n = 1'b1;
    logic        i_flag = 1'b1;
    logic        fetch_req = 1'b0;
    logic        brk = 1'b0;
    logic        ack = 1'b0;
    logic        int_take;
    logic [15:0] vector;
    logic        push_b;
    logic        set_i;
    logic        busy;

    always #5 clk = ~clk;

    interrupt_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .nmi_n    (nmi_n),
        .irq_n    (irq_n),
        .i_flag   (i_flag),
        .fetch_req(fetch_req),
        .brk      (brk),
        .ack      (ack),
        .int_take (int_take),
        .vector   (vector),
        .push_b   (push_b),
        .set_i    (set_i),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_takes  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history, pending-reset / idle / servicing phase
    localparam int PH_RST  = 0;
    localparam int PH_IDLE = 1;
    localparam int PH_SERV = 2;

    bit [2:0]    nmi_h;
    bit [2:0]    irq_h;
    int          phase;
    bit          m_latch;
    bit          m_src_nmi;
    bit          m_take;
    bit          m_seti;
    bit          m_pb;
    bit [15:0]   m_vec;

    task automatic model_reset();
        nmi_h     = 3'b111;
        irq_h     = 3'b111;
        phase     = PH_RST;
        m_latch   = 1'b0;
        m_src_nmi = 1'b0;
        m_take    = 1'b0;
        m_seti    = 1'b0;
        m_pb      = 1'b0;
        m_vec     = 16'hFFFC;
    endtask

    task automatic model_step();
        bit nmi_edge;
        bit irq_pend;
        bit clr;
        if (rst) begin
            model_reset();
            return;
        end
        // synchronized pin = value seen two edges ago
        nmi_edge = nmi_h[2] & ~nmi_h[1];
        irq_pend = ~irq_h[1] & ~i_flag;
        clr      = 1'b0;
        m_take   = 1'b0;
        m_seti   = 1'b0;
        if (phase == PH_RST && fetch_req) begin
            m_take = 1'b1; m_vec = 16'hFFFC; m_pb = 1'b0; m_src_nmi = 1'b0; phase = PH_SERV;
        end else if (phase == PH_IDLE && fetch_req && (m_latch || brk || irq_pend)) begin
            m_take = 1'b1;
            m_vec = m_latch ? 16'hFFFA : 16'hFFFE;
            m_pb = brk; m_src_nmi = m_latch; phase = PH_SERV;
        end else if (phase == PH_SERV && ack) begin
            m_seti = 1'b1; clr = m_src_nmi; phase = PH_IDLE;
        end
        if (nmi_edge) m_latch = 1'b1;
        else if (clr) m_latch = 1'b0;
        nmi_h = {nmi_h[1:0], nmi_n};
        irq_h = {irq_h[1:0], irq_n};
    endtask

    // Drive one cycle of inputs, advance model, compare every output
    task automatic cycle(input bit r, input bit nm, input bit iq, input bit ifl,
                         input bit fr, input bit bk, input bit ak);
        rst = r; nmi_n = nm; irq_n = iq; i_flag = ifl;
        fetch_req = fr; brk = bk; ack = ak;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (int_take === 1'b1) n_takes++;
        check("int_take", 32'(int_take), 32'(m_take));
        check("set_i",    32'(set_i),    32'(m_seti));
        check("busy",     32'(busy),     32'(phase == PH_SERV));
        check("vector",   32'(vector),   32'(m_vec));
        check("push_b",   32'(push_b),   32'(m_pb));
        if (int_take === 1'b1 && set_i === 1'b1) check("take_seti_excl", 32'd1, 32'd0);
    endtask

    initial begin
        bit rn;
        bit ri;
        int t0;
        model_reset();
        @(negedge clk);
        check("rst_take",   32'(int_take), 32'd0);
        check("rst_vector", 32'(vector),   32'hFFFC);
        check("rst_busy",   32'(busy),     32'd0);

        // Reset service wins despite IRQ low
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 1, 0);
        check("r31_take", 32'(int_take), 32'd1);
        check("r31_vec",  32'(vector),   32'hFFFC);
        check("r31_pb",   32'(push_b),   32'd0);
        cycle(0, 1, 1, 1, 0, 0, 1);
        check("r31_seti_early", 32'(set_i), 32'd1);
        check("r31_busy", 32'(busy), 32'd0);

        // Held-low NMI yields exactly one take
        t0 = n_takes;
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 0, 0);
        check("r32_vec", 32'(vector), 32'hFFFA);
        cycle(0, 0, 1, 1, 0, 0, 1);
        cycle(0, 0, 1, 1, 1, 0, 0);
        check("r32_no_take", 32'(int_take), 32'd0);
        cycle(0, 0, 1, 1, 0, 0, 1);
        check("r32_takes", 32'(n_takes - t0), 32'd1);

        // IRQ masked by I, then taken
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 1, 0, 0);
        check("r33_masked", 32'(int_take), 32'd0);
        cycle(0, 1, 0, 0, 1, 0, 0);
        check("r33_vec", 32'(vector), 32'hFFFE);
        check("r33_pb",  32'(push_b), 32'd0);
        cycle(0, 1, 1, 1, 0, 0, 1);

        // BRK hijacked by pending NMI
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 1, 0);
        check("r34_vec", 32'(vector), 32'hFFFA);
        check("r34_pb",  32'(push_b), 32'd1);
        cycle(0, 0, 1, 1, 0, 0, 1);

        // NMI edge during IRQ service survives the ack
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 0, 0);
        check("r35_irq_vec", 32'(vector), 32'hFFFE);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0);
        check("r35_nmi_vec", 32'(vector), 32'hFFFA);
        cycle(0, 0, 1, 1, 0, 0, 1);

        // Reset abandons a service with no set_i
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 1);
        check("r36_busy", 32'(busy),   32'd0);
        check("r36_seti", 32'(set_i),  32'd0);
        check("r36_vec",  32'(vector), 32'hFFFC);
        cycle(0, 1, 0, 0, 0, 0, 1);
        check("r36_seti_after", 32'(set_i), 32'd0);
        cycle(0, 1, 0, 0, 1, 0, 0);
        check("r36_vec_take", 32'(vector), 32'hFFFC);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Random traffic
        rn = 1'b1;
        ri = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) rn = ~rn;
            if ($urandom_range(7) == 0)  ri = ~ri;
            cycle(bit'($urandom_range(199) == 0), rn, ri, bit'($urandom_range(1)),
                  bit'($urandom_range(2) == 0), bit'($urandom_range(3) == 0),
                  bit'($urandom_range(3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset; all registers clear immediately on assertion, independent of clk.
REQ-003 SHALL have port nmi_n, input, 1, external NMI pin, active-low, asynchronous to clk.
REQ-004 SHALL have port irq_n, input, 1, external IRQ pin, active-low level, asynchronous to clk.
REQ-005 SHALL have port i_flag, input, 1, current I bit from the status register.
REQ-006 SHALL have port fetch_req, input, 1, one-cycle pulse from the sequencer at each instruction boundary.
REQ-007 SHALL have port brk, input, 1, qualifies fetch_req: the fetched opcode is BRK.
REQ-008 SHALL have port ack, input, 1, one-cycle pulse: push and vector fetch complete.
REQ-009 SHALL have port int_take, output, 1, registered one-cycle pulse: enter the interrupt sequence.
REQ-010 SHALL have port vector, output, 16, vector address of the sequence being serviced.
REQ-011 SHALL have port push_b, output, 1, B bit value to push with P.
REQ-012 SHALL have port set_i, output, 1, one-cycle enable strobe to the status register to set I.
REQ-013 SHALL have port busy, output, 1, high while in SERVICE.

Function
REQ-014 SHALL pass nmi_n and irq_n each through a two-flop synchronizer; synchronizer flops reset to 1.
REQ-015 SHALL set nmi_latch on a 1->0 transition of synchronized nmi_n; a held-low level sets it only once.
REQ-016 SHALL treat IRQ as pending when synchronized irq_n = 0 and i_flag = 0, evaluated in the fetch_req cycle; IRQ is not latched.
REQ-017 SHALL implement FSM states RST_PEND, IDLE, SERVICE; reset state RST_PEND.
REQ-018 RST_PEND: on fetch_req -> int_take next cycle, vector 16'hFFFC, push_b 0, go SERVICE.
REQ-019 IDLE: on fetch_req with any source -> int_take next cycle, go SERVICE; with no source, stay IDLE, no pulse.
REQ-020 SHALL apply priority reset > NMI > BRK > IRQ; vectors: NMI 16'hFFFA, BRK and IRQ 16'hFFFE.
REQ-021 SHALL set push_b = 1 whenever brk was high at the accepted fetch_req, including when NMI wins the vector (BRK hijack).
REQ-022 SHALL capture source, vector and push_b in registers at acceptance and hold them stable until return to IDLE.
REQ-023 SERVICE: ignore fetch_req and brk; on ack -> set_i pulses high exactly one cycle later, FSM goes IDLE in that same cycle.
REQ-024 SHALL clear nmi_latch on ack only if the serviced source was NMI; an NMI edge in the same cycle as that clear leaves nmi_latch set.
REQ-025 SHALL keep nmi_latch set across IRQ/BRK services so NMI is taken at the next fetch_req.
REQ-026 ack outside SERVICE SHALL have no effect.
REQ-027 int_take and set_i SHALL never be high in the same cycle.

Reset
REQ-028 On rst: state RST_PEND, nmi_latch 0, int_take 0, set_i 0, busy 0, push_b 0, vector 16'hFFFC.
REQ-029 rst asserted in SERVICE SHALL abandon the sequence with no set_i pulse; the next fetch_req after release services reset.
REQ-030 After rst release, the first fetch_req SHALL always service reset regardless of nmi_n, irq_n, brk.

Verification
REQ-031 Release rst, fetch_req with irq_n=0 -> int_take, vector FFFC, push_b 0; ack -> set_i one cycle later, busy 0.
REQ-032 IDLE, nmi_n 1->0 held low, two fetch_req/ack rounds -> exactly one NMI take (FFFA); second fetch_req yields no int_take.
REQ-033 IDLE, irq_n=0: i_flag=1 at fetch_req -> no take; i_flag=0 -> take, FFFE, push_b 0.
REQ-034 IDLE, pending NMI latch, fetch_req with brk=1 -> vector FFFA, push_b 1.
REQ-035 SERVICE(IRQ), NMI edge then ack -> nmi_latch stays set; next fetch_req -> FFFA take.
REQ-036 SERVICE, assert rst before ack -> outputs at reset values, no set_i; next fetch_req -> FFFC.
